// File: rtl/clock_timer_if.sv
// Bus bundle for one clock_timer field: control/button inputs and the count/wrap outputs.
interface clock_timer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             power;
  logic             enable;
  logic             tick;
  logic             add_time;
  logic             sub_time;
  logic [WIDTH-1:0] count;
  logic             sig_end;

  modport master (
    output power, enable, tick, add_time, sub_time,
    input  count, sig_end
  );

  modport slave (
    input  power, enable, tick, add_time, sub_time,
    output count, sig_end
  );
endinterface

// File: rtl/clock_timer.sv
// Modulo-RANGE clock field: counts on tick in run mode, steps on button presses in set mode.
// Define TIMER_AUTOREPEAT_EN to enable auto-repeat while a set button is held.
module clock_timer #(
  parameter int unsigned     WIDTH         = 32,
  parameter longint unsigned RANGE         = 60,
  parameter int unsigned     REPEAT_DELAY  = 8,
  parameter int unsigned     REPEAT_PERIOD = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  clock_timer_if.slave  bus
);

  localparam logic [WIDTH-1:0] MaxCount = WIDTH'(RANGE - 64'd1);
  localparam logic [WIDTH-1:0] One      = 1;

  typedef enum logic [1:0] {
    MODE_OFF,
    MODE_RUN,
    MODE_SET
  } mode_e;

  mode_e            mode;
  logic             add_hist;
  logic             sub_hist;
  logic             add_rise;
  logic             sub_rise;
  logic             step_up;
  logic             step_dn;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             sig_end_q;
  logic             sig_end_d;

  always_comb begin
    mode = MODE_OFF;
    if (bus.power) begin
      mode = bus.enable ? MODE_RUN : MODE_SET;
    end
  end

  assign add_rise = bus.add_time & ~add_hist;
  assign sub_rise = bus.sub_time & ~sub_hist;

`ifdef TIMER_AUTOREPEAT_EN
  // rep_cnt == 0 means idle; it is armed by a single press and cleared by anything else.
  logic [31:0] rep_cnt;
  logic [31:0] rep_cnt_d;
  logic        rep_on;
  logic        rep_on_d;
  logic        rep_fire;
  logic        hold_one;

  assign hold_one = (bus.add_time & add_hist & ~bus.sub_time) |
                    (bus.sub_time & sub_hist & ~bus.add_time);

  always_comb begin
    rep_cnt_d = '0;
    rep_on_d  = 1'b0;
    rep_fire  = 1'b0;
    if (mode == MODE_SET) begin
      if (add_rise ^ sub_rise) begin
        rep_cnt_d = 32'd1;
      end else if (hold_one && (rep_cnt != '0)) begin
        if (rep_cnt == (rep_on ? REPEAT_PERIOD : REPEAT_DELAY)) begin
          rep_fire  = 1'b1;
          rep_cnt_d = 32'd1;
          rep_on_d  = 1'b1;
        end else begin
          rep_cnt_d = rep_cnt + 32'd1;
          rep_on_d  = rep_on;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rep_cnt <= '0;
      rep_on  <= 1'b0;
    end else begin
      rep_cnt <= rep_cnt_d;
      rep_on  <= rep_on_d;
    end
  end

  assign step_up = (mode == MODE_SET) & ((add_rise & ~sub_rise) | (rep_fire & bus.add_time));
  assign step_dn = (mode == MODE_SET) & ((sub_rise & ~add_rise) | (rep_fire & bus.sub_time));
`else
  assign step_up = (mode == MODE_SET) & add_rise & ~sub_rise;
  assign step_dn = (mode == MODE_SET) & sub_rise & ~add_rise;
`endif

  always_comb begin
    count_d   = count_q;
    sig_end_d = 1'b0;
    unique case (mode)
      MODE_OFF: count_d = '0;
      MODE_RUN: begin
        if (bus.tick) begin
          if (count_q == MaxCount) begin
            count_d   = '0;
            sig_end_d = 1'b1;
          end else begin
            count_d = count_q + One;
          end
        end
      end
      MODE_SET: begin
        if (step_up) begin
          count_d = (count_q == MaxCount) ? '0 : count_q + One;
        end else if (step_dn) begin
          count_d = (count_q == '0) ? MaxCount : count_q - One;
        end
      end
      default: count_d = '0;
    endcase
  end

  // Button history updates in every mode so a press held across a mode switch never steps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= '0;
      sig_end_q <= 1'b0;
      add_hist  <= 1'b0;
      sub_hist  <= 1'b0;
    end else begin
      count_q   <= count_d;
      sig_end_q <= sig_end_d;
      add_hist  <= bus.add_time;
      sub_hist  <= bus.sub_time;
    end
  end

  assign bus.count   = count_q;
  assign bus.sig_end = sig_end_q;

endmodule

// File: tb/tb_clock_timer.sv
// Directed bench for clock_timer (RANGE=5) checked every cycle against a behavioural model.
module tb_clock_timer;

  localparam int unsigned W = 8;
  localparam int          R = 5;
  localparam int          D = 8;
  localparam int          P = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  clock_timer_if #(.WIDTH(W)) bus ();

  clock_timer #(
    .WIDTH(W),
    .RANGE(R),
    .REPEAT_DELAY(D),
    .REPEAT_PERIOD(P)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Model state: value, wrap flag, previous buttons, cycles since single-button press (-1 = none).
  int m_count;
  bit m_end;
  bit m_add_prev;
  bit m_sub_prev;
  int m_hold;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count    = 0;
    m_end      = 1'b0;
    m_add_prev = 1'b0;
    m_sub_prev = 1'b0;
    m_hold     = -1;
  endtask

  task automatic model_edge();
    bit pa;
    bit ps;
    int dir;
    pa  = bus.add_time && !m_add_prev;
    ps  = bus.sub_time && !m_sub_prev;
    dir = 0;
    if (!bus.power) begin
      m_count = 0;
      m_end   = 1'b0;
      m_hold  = -1;
    end else if (bus.enable) begin
      m_end  = 1'b0;
      m_hold = -1;
      if (bus.tick) begin
        m_count = (m_count + 1) % R;
        m_end   = (m_count == 0);
      end
    end else begin
      m_end = 1'b0;
      if (pa && !ps) dir = 1;
      else if (ps && !pa) dir = -1;
      if (pa != ps) begin
        m_hold = 0;
      end else if (m_hold >= 0 && (bus.add_time != bus.sub_time)) begin
        m_hold++;
`ifdef TIMER_AUTOREPEAT_EN
        if (m_hold == D || (m_hold > D && ((m_hold - D) % P) == 0))
          dir = bus.add_time ? 1 : -1;
`endif
      end else begin
        m_hold = -1;
      end
      m_count = (m_count + R + dir) % R;
    end
    m_add_prev = bus.add_time;
    m_sub_prev = bus.sub_time;
  endtask

  task automatic set_in(input bit p, input bit e, input bit t, input bit a, input bit s);
    bus.power    = p;
    bus.enable   = e;
    bus.tick     = t;
    bus.add_time = a;
    bus.sub_time = s;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      model_edge();
      @(posedge clk);
      #1;
      chk("count", int'(bus.count), m_count);
      chk("sig_end", int'(bus.sig_end), int'(m_end));
    end
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0);
    model_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", int'(bus.count), 0);
    chk("reset_sig_end", int'(bus.sig_end), 0);

    // Free-running count with wrap pulses
    reset_n = 1'b1;
    set_in(1, 1, 1, 0, 0);
    step(5);
    chk("wrap_count", int'(bus.count), 0);
    chk("wrap_sig_end", int'(bus.sig_end), 1);
    step(7);
    chk("run_count", int'(bus.count), 2);

    // Buttons ignored in run mode
    set_in(1, 1, 0, 1, 0); step(1);
    set_in(1, 1, 0, 0, 0); step(1);
    set_in(1, 1, 0, 0, 1); step(1);
    set_in(1, 1, 0, 0, 0); step(1);
    chk("run_btn_ignored", int'(bus.count), 2);

    // Power drop clears, buttons ignored while off
    set_in(0, 1, 1, 0, 0); step(1);
    chk("power_off_count", int'(bus.count), 0);
    set_in(0, 0, 0, 1, 0); step(1);
    set_in(0, 0, 0, 0, 0); step(1);
    set_in(0, 0, 0, 0, 1); step(1);
    set_in(0, 0, 0, 0, 0); step(1);
    chk("power_off_btn", int'(bus.count), 0);

    // Power restored, then asynchronous reset at count 3
    set_in(1, 1, 1, 0, 0); step(3);
    chk("restore_count", int'(bus.count), 3);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("async_reset_count", int'(bus.count), 0);
    chk("async_reset_sig_end", int'(bus.sig_end), 0);
    reset_n = 1'b1;
    step(1);
    chk("post_reset_count", int'(bus.count), 1);
    step(3);
    chk("reach_four", int'(bus.count), 4);

    // Set mode stepping
    set_in(1, 0, 0, 0, 0); step(1);
    set_in(1, 0, 0, 1, 0); step(1);
    chk("set_add_wrap", int'(bus.count), 0);
    chk("set_add_no_end", int'(bus.sig_end), 0);
    set_in(1, 0, 0, 0, 0); step(1);
    set_in(1, 0, 0, 0, 1); step(1);
    chk("set_sub_wrap", int'(bus.count), 4);
    set_in(1, 0, 0, 0, 0); step(1);
    set_in(1, 0, 0, 1, 0); step(2);
    chk("set_add_held2", int'(bus.count), 0);
    set_in(1, 0, 0, 0, 0); step(1);
    set_in(1, 0, 0, 1, 1); step(1);
    chk("set_both", int'(bus.count), 0);
    set_in(1, 0, 0, 0, 0); step(1);

    // Button held across run->set switch must not step
    set_in(1, 1, 0, 1, 0); step(1);
    set_in(1, 0, 0, 1, 0); step(2);
    chk("held_across_switch", int'(bus.count), 0);
    set_in(1, 0, 0, 0, 0); step(1);

    // Long hold from 0
    set_in(1, 0, 0, 1, 0); step(20);
`ifdef TIMER_AUTOREPEAT_EN
    chk("long_hold", int'(bus.count), 4);
`else
    chk("long_hold", int'(bus.count), 1);
`endif
    set_in(1, 0, 0, 0, 0); step(1);

    // Sub pulses through zero, then gated ticks
    for (int k = 0; k < 3; k++) begin
      set_in(1, 0, 0, 0, 1); step(1);
      set_in(1, 0, 0, 0, 0); step(1);
    end
    for (int k = 0; k < 8; k++) begin
      set_in(1, 1, k[0], 0, 0); step(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
